// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC generation, 1-cycle-latency IMEM reads,
// one-entry skid buffer for downstream stall, redirect with flush, and
// combinational field split of the presented instruction.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               imem_rd_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               instr_valid,
  output logic [31:0]        instr,
  output logic [31:0]        pc_out,
  output logic [6:0]         opcode,
  output logic [4:0]         rd,
  output logic [2:0]         funct3,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [6:0]         funct7,
  output logic [11:0]        imm12,
  output logic [19:0]        imm20
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] fetch_pc;
  logic        pending;
  logic [31:0] pend_pc;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        issue;
  logic        load;

  // Issue and output-load decisions for the current cycle
  always_comb begin
    issue = !rst && !redirect && !skid_valid && !(stall && instr_valid && pending);
    load  = !instr_valid || !stall;
  end

  assign imem_rd_en = issue;
  assign imem_addr  = fetch_pc[IMEM_AW+1:2];

  // PC, in-flight read, skid buffer and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      pending     <= 1'b0;
      pend_pc     <= RESET_PC;
      skid_valid  <= 1'b0;
      skid_instr  <= NOP;
      skid_pc     <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= NOP;
      pc_out      <= RESET_PC;
    end else if (redirect) begin
      fetch_pc    <= redirect_pc & 32'hFFFF_FFFC;
      pending     <= 1'b0;
      skid_valid  <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= NOP;
    end else begin
      pending <= issue;
      if (issue) begin
        pend_pc  <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (load) begin
        if (skid_valid) begin
          // Skid entry is older than any same-cycle response, so it goes first
          instr_valid <= 1'b1;
          instr       <= skid_instr;
          pc_out      <= skid_pc;
          skid_valid  <= pending;
          if (pending) begin
            skid_instr <= imem_rdata;
            skid_pc    <= pend_pc;
          end
        end else if (pending) begin
          instr_valid <= 1'b1;
          instr       <= imem_rdata;
          pc_out      <= pend_pc;
        end else begin
          instr_valid <= 1'b0;
          instr       <= NOP;
        end
      end else if (pending) begin
        skid_valid <= 1'b1;
        skid_instr <= imem_rdata;
        skid_pc    <= pend_pc;
      end
    end
  end

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];
  assign imm12  = instr[31:20];
  assign imm20  = instr[31:12];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed + random-stall bench for instr_fetch with a PC scoreboard.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_rd_en;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        instr_valid;
  logic [31:0] instr, pc_out;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [11:0] imm12;
  logic [19:0] imm20;

  int checks = 0;
  int errors = 0;
  int consumed = 0;
  int start_cnt;
  logic mon_en = 1'b0;
  logic [31:0] exp_q[$];

  instr_fetch #(.RESET_PC(32'h0000_0000), .IMEM_AW(12)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .pc_out(pc_out), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1),
    .rs2(rs2), .funct7(funct7), .imm12(imm12), .imm20(imm20)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [11:0] a);
    return 32'h0010_0093 + ({20'd0, a} << 20);
  endfunction

  // Synchronous instruction memory, 1-cycle read latency
  always @(posedge clk) if (imem_rd_en) imem_rdata <= memword(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(base + 32'(k) * 32'd4);
  endtask

  // Per-cycle monitor: scoreboard pop on consumption, field slices, invariants
  always @(negedge clk) begin
    if (mon_en) begin
      logic [31:0] e;
      check("f_opcode", {25'd0, opcode}, {25'd0, instr[6:0]});
      check("f_rd",     {27'd0, rd},     {27'd0, instr[11:7]});
      check("f_funct3", {29'd0, funct3}, {29'd0, instr[14:12]});
      check("f_rs1",    {27'd0, rs1},    {27'd0, instr[19:15]});
      check("f_rs2",    {27'd0, rs2},    {27'd0, instr[24:20]});
      check("f_funct7", {25'd0, funct7}, {25'd0, instr[31:25]});
      check("f_imm12",  {20'd0, imm12},  {20'd0, instr[31:20]});
      check("f_imm20",  {12'd0, imm20},  {12'd0, instr[31:12]});
      if (!instr_valid) check("invalid_nop", instr, NOP);
      check("skid_collision",
            {31'd0, !rst && !redirect && (!instr_valid || !stall) && dut.skid_valid && dut.pending}, 32'd0);
      check("outstanding", {31'd0, dut.skid_valid && imem_rd_en}, 32'd0);
      if (!rst && !redirect && instr_valid && !stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_empty: observed pc %h expected none", pc_out);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", pc_out, e);
          check("sb_instr", instr, memword(e[13:2]));
          consumed++;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_pc", pc_out, 32'd0);
    check("rst_rden", {31'd0, imem_rd_en}, 32'd0);
    mon_en = 1'b1;

    // Free run from reset
    nxt(); rst = 1'b0; push_seq(32'd0, 64);
    @(negedge clk);
    check("c0_rden", {31'd0, imem_rd_en}, 32'd1);
    check("c0_addr", {20'd0, imem_addr}, 32'd0);
    nxt(); @(negedge clk);
    check("c1_valid", {31'd0, instr_valid}, 32'd0);
    nxt(); @(negedge clk);
    check("c2_valid", {31'd0, instr_valid}, 32'd1);
    check("c2_pc", pc_out, 32'd0);
    check("c2_opcode", {25'd0, opcode}, 32'h13);
    check("c2_rd", {27'd0, rd}, 32'd1);
    check("c2_imm12", {20'd0, imm12}, 32'd1);
    nxt(); @(negedge clk);
    check("c3_pc", pc_out, 32'd4);

    // Stall 3 cycles while pc_out=8
    nxt(); stall = 1'b1; @(negedge clk);
    check("stall_hold0", pc_out, 32'd8);
    nxt(); @(negedge clk);
    check("stall_hold1", pc_out, 32'd8);
    check("skid_valid", {31'd0, dut.skid_valid}, 32'd1);
    check("skid_pc", dut.skid_pc, 32'd12);
    nxt(); @(negedge clk);
    check("stall_hold2", pc_out, 32'd8);
    nxt(); stall = 1'b0; @(negedge clk);
    check("release_pc", pc_out, 32'd8);
    nxt(); @(negedge clk);
    check("drain_pc", pc_out, 32'd12);
    repeat (4) nxt();

    // Redirect while stalled with skid full
    stall = 1'b1;
    nxt(); @(negedge clk);
    check("pre_redir_skid", {31'd0, dut.skid_valid}, 32'd1);
    nxt(); redirect = 1'b1; redirect_pc = 32'h0000_0103; push_seq(32'h100, 64);
    @(negedge clk);
    check("redir_rden", {31'd0, imem_rd_en}, 32'd0);
    nxt(); redirect = 1'b0; stall = 1'b0; @(negedge clk);
    check("redir1_valid", {31'd0, instr_valid}, 32'd0);
    check("redir1_instr", instr, NOP);
    check("redir1_rd", {27'd0, rd}, 32'd0);
    check("redir1_rden", {31'd0, imem_rd_en}, 32'd1);
    check("redir1_addr", {20'd0, imem_addr}, 32'h40);
    nxt(); @(negedge clk);
    check("redir2_valid", {31'd0, instr_valid}, 32'd0);
    nxt(); @(negedge clk);
    check("redir3_valid", {31'd0, instr_valid}, 32'd1);
    check("redir3_pc", pc_out, 32'h100);
    repeat (5) nxt();

    // Reset mid-stream with skid full
    stall = 1'b1;
    nxt(); @(negedge clk);
    check("pre_rst_skid", {31'd0, dut.skid_valid}, 32'd1);
    nxt(); rst = 1'b1; push_seq(32'd0, 64);
    @(negedge clk);
    check("midrst_rden", {31'd0, imem_rd_en}, 32'd0);
    nxt(); rst = 1'b0; stall = 1'b0; @(negedge clk);
    check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    check("midrst_instr", instr, NOP);
    check("midrst_pc", pc_out, 32'd0);
    check("midrst_skid", {31'd0, dut.skid_valid}, 32'd0);
    check("midrst_pend", {31'd0, dut.pending}, 32'd0);
    check("midrst_addr", {20'd0, imem_addr}, 32'd0);
    nxt(); nxt(); @(negedge clk);
    check("midrst_c2_valid", {31'd0, instr_valid}, 32'd1);
    check("midrst_c2_pc", pc_out, 32'd0);
    repeat (3) nxt();

    // PC wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; push_seq(32'hFFFF_FFFC, 1200);
    nxt(); redirect = 1'b0; @(negedge clk);
    check("wrap_addr0", {20'd0, imem_addr}, 32'hFFF);
    nxt(); @(negedge clk);
    check("wrap_addr1", {20'd0, imem_addr}, 32'd0);
    nxt(); @(negedge clk);
    check("wrap_pc0", pc_out, 32'hFFFF_FFFC);
    nxt(); @(negedge clk);
    check("wrap_pc1", pc_out, 32'd0);

    // Random stall against the scoreboard
    start_cnt = consumed;
    for (int i = 0; i < 1000; i++) begin
      nxt();
      stall = 1'($urandom_range(0, 1));
    end
    nxt(); stall = 1'b0;
    repeat (4) nxt();
    check("random_progress", {31'd0, (consumed - start_cnt) >= 200}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the single-issue RV32 lab core, directly upstream of the control unit. Maintains the program counter, issues word reads to a synchronous instruction memory with 1-cycle read latency, and registers each returned word with its PC. It presents the split instruction fields (opcode, rd, funct3, rs1, rs2, funct7, imm12, imm20) to the control unit and datapath. Supports downstream stall through a one-entry skid buffer and PC redirect with flush.

## Interface
- RESET_PC, 32'h0000_0000, byte address of the first fetch; bits [1:0] must be 0.
- IMEM_AW, 12, instruction memory word-address width (4096 words).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  downstream cannot accept; hold the presented instruction.
- redirect  in  1  flush and refetch from redirect_pc.
- redirect_pc  in  32  redirect byte address; bits [1:0] ignored.
- imem_rd_en  out  1  read strobe to instruction memory.
- imem_addr  out  IMEM_AW  word address, pc[IMEM_AW+1:2].
- imem_rdata  in  32  read data, valid the cycle after imem_rd_en.
- instr_valid  out  1  instr/pc_out/fields hold a real instruction.
- instr  out  32  registered instruction word.
- pc_out  out  32  byte PC of instr.
- opcode  out  7  instr[6:0]; rd 5 instr[11:7]; funct3 3 instr[14:12]; rs1 5 instr[19:15]; rs2 5 instr[24:20]; funct7 7 instr[31:25]; imm12 12 instr[31:20]; imm20 20 instr[31:12]. All fields are combinational from instr.

## Operation
- State: fetch_pc (next address to issue), pending flag plus pend_pc (read issued last cycle), skid buffer (skid_valid, skid_instr, skid_pc), and output register (instr_valid, instr, pc_out).
- Issue rule: imem_rd_en = !rst & !redirect & !skid_valid & !(stall & instr_valid & pending). On issue: pending<=1, pend_pc<=fetch_pc, fetch_pc<=fetch_pc+4. fetch_pc wraps modulo 2^32; imem_addr is truncated.
- Output load condition: load = !instr_valid | !stall.
- Response (pending=1) goes to the output register when load=1 and skid_valid=0. Otherwise it goes to the skid buffer.
- When load=1 and skid_valid=1, the skid entry moves to the output register and skid_valid<=0. A same-cycle response then goes into the skid buffer. This cannot occur under the issue rule, and the bench asserts it never does.
- When load=1 and nothing is available, instr_valid<=0 and instr<=32'h0000_0013 (NOP). pc_out holds.
- Ordering: instructions leave in strict program order. None are dropped or duplicated except on redirect.
- Redirect, when rst=0, takes priority over everything except reset:
  - instr_valid<=0, instr<=NOP, skid_valid<=0.
  - Any pending response is discarded (pending<=0).
  - fetch_pc<={redirect_pc[31:2],2'b00}.
  - Redirect is honoured even while stall=1.
- Invalid slots present NOP fields (addi x0,x0,0), so the control unit decodes a harmless instruction.

## Timing
- Reset values (on rst): instr_valid=0, instr=32'h0000_0013, pc_out=RESET_PC, fetch_pc=RESET_PC, pending=0, skid_valid=0, imem_rd_en=0.
- Reset mid-operation discards pending and skid contents.
- Cycle 0 is the first cycle with rst=0: imem_rd_en=1, imem_addr=RESET_PC>>2.
- Cycle 1: memory data returns and is registered.
- Cycle 2: instr_valid=1 with the first instruction.
- Latency is 2 cycles from rd_en to instr_valid. Throughput is 1 instruction per cycle with stall=0.
- Stall:
  - Output register holds while stall=1 and instr_valid=1.
  - At most one further response is captured, into the skid buffer.
  - Issue stops while skid_valid=1.
  - On release, the skid entry is presented in the next cycle. Issue resumes the same cycle skid drains.
- Redirect in cycle N: imem_rd_en=0 in N, first read of the target in N+1, instr_valid=1 with the target in N+3.
- stall asserted during the fill after reset: output loads freely while instr_valid=0. Stall only holds valid data.

## Test plan
- Reset then free run, memory word k = 32'h00100093+(k<<20), stall=0.
  - Expect instr_valid rising at cycle 2 and pc_out 0,4,8,... one per cycle.
  - For the first word: opcode=7'h13, rd=1, imm12=1.
- Stall held 3 cycles while pc_out=8.
  - Expect pc_out=8 held throughout and skid_valid set with PC 12.
  - After release: 12, 16, ... with no gap beyond one cycle and no duplicate or lost PCs.
- Redirect to 32'h0000_0103 while stalled and skid full.
  - Expect instr_valid=0 and NOP fields next cycle.
  - Read address 0x40 issued the following cycle.
  - pc_out=0x100 three cycles after redirect; old PCs never appear.
- rst asserted for 1 cycle mid-stream with pending and skid valid.
  - Expect all outputs at their reset values.
  - Refetch from RESET_PC; no stale instruction emerges.
- PC wrap: redirect to 32'hFFFF_FFFC.
  - Expect pc_out FFFF_FFFC then 0000_0000.
  - imem_addr all-ones then 0.
- Random stall (50%) over 1000 cycles against a reference model.
  - Expect in-order PCs, at most one outstanding read plus skid, and fields equal to instr bit slices every cycle.
